// File: rtl/ay_regs.sv
// AY-3-891x CPU register file: address-latch/data-port decode of R0-R15,
// static outputs to the tone/noise/mixer/amp/envelope blocks and the envelope restart tick.
module ay_regs #(
   parameter logic [3:0] ADDR_HI       = 4'h0,
   parameter bit         ATOMIC_PERIOD = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr,
   input  logic        rd,
   input  logic        a0,
   input  logic [7:0]  din,
   output logic [7:0]  dout,
   output logic        rd_valid,
   output logic [11:0] tone_a,
   output logic [11:0] tone_b,
   output logic [11:0] tone_c,
   output logic [4:0]  noise_period,
   output logic [7:0]  mixer,
   output logic [4:0]  amp_a,
   output logic [4:0]  amp_b,
   output logic [4:0]  amp_c,
   output logic [15:0] env_period,
   output logic [3:0]  env_shape,
   output logic        env_shape_tick,
   output logic [7:0]  io_a_out,
   output logic [7:0]  io_b_out,
   input  logic [7:0]  io_a_in,
   input  logic [7:0]  io_b_in
);

   logic [7:0] r_regs [16];
   logic [3:0] r_addr;
   logic       r_addr_valid;
   logic       w_data_wr;
   logic       w_rd_accept;
   logic [7:0] w_rd_data;

   // Values are stored already masked, so readback of unimplemented bits is 0 for free.
   function automatic logic [7:0] mask_reg(input logic [3:0] addr, input logic [7:0] data);
      case (addr)
         4'd1, 4'd3, 4'd5, 4'd13:  mask_reg = {4'h0, data[3:0]};
         4'd6, 4'd8, 4'd9, 4'd10:  mask_reg = {3'h0, data[4:0]};
         default:                  mask_reg = data;
      endcase
   endfunction

   assign w_data_wr   = wr & a0 & r_addr_valid;
   assign w_rd_accept = rd & ~wr;

   always_comb begin
      // NOTE: default assigned first so no path leaves w_rd_data unassigned (no latch).
      w_rd_data = r_regs[r_addr];
      if (r_addr == 4'd14 && !r_regs[7][6]) w_rd_data = io_a_in;
      if (r_addr == 4'd15 && !r_regs[7][7]) w_rd_data = io_b_in;
   end

   // NOTE: the register array is reset explicitly because every output must read 0 after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) r_regs[i] <= '0;
         r_addr         <= '0;
         r_addr_valid   <= 1'b0;
         dout           <= '0;
         rd_valid       <= 1'b0;
         env_shape_tick <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         env_shape_tick <= w_data_wr && (r_addr == 4'd13);
         rd_valid       <= w_rd_accept;
         if (wr && !a0) begin
            r_addr_valid <= (din[7:4] == ADDR_HI);
            if (din[7:4] == ADDR_HI) r_addr <= din[3:0];
         end
         if (w_data_wr) r_regs[r_addr] <= mask_reg(r_addr, din);
         if (w_rd_accept) dout <= (a0 && r_addr_valid) ? w_rd_data : 8'hFF;
      end
   end

   generate
      if (ATOMIC_PERIOD) begin : g_atomic
         // R11 acts as the low-byte shadow; the full period commits on the R12 write.
         logic [15:0] r_env_period;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset)                              r_env_period <= '0;
            else if (w_data_wr && r_addr == 4'd12)   r_env_period <= {din, r_regs[11]};
         end
         assign env_period = r_env_period;
      end else begin : g_direct
         assign env_period = {r_regs[12], r_regs[11]};
      end
   endgenerate

   assign tone_a       = {r_regs[1][3:0], r_regs[0]};
   assign tone_b       = {r_regs[3][3:0], r_regs[2]};
   assign tone_c       = {r_regs[5][3:0], r_regs[4]};
   assign noise_period = r_regs[6][4:0];
   assign mixer        = r_regs[7];
   assign amp_a        = r_regs[8][4:0];
   assign amp_b        = r_regs[9][4:0];
   assign amp_c        = r_regs[10][4:0];
   assign env_shape    = r_regs[13][3:0];
   assign io_a_out     = r_regs[14];
   assign io_b_out     = r_regs[15];

endmodule

// File: tb/tb_ay_regs.sv
// Directed bench for ay_regs: instance 0 uses defaults, instance 1 uses ADDR_HI=1, ATOMIC_PERIOD=1.
module tb_ay_regs;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr [2];
   logic        rd [2];
   logic        a0 [2];
   logic [7:0]  din [2];
   logic [7:0]  io_a_in [2];
   logic [7:0]  io_b_in [2];
   logic [7:0]  dout [2];
   logic        rd_valid [2];
   logic [11:0] tone_a [2];
   logic [11:0] tone_b [2];
   logic [11:0] tone_c [2];
   logic [4:0]  noise_period [2];
   logic [7:0]  mixer [2];
   logic [4:0]  amp_a [2];
   logic [4:0]  amp_b [2];
   logic [4:0]  amp_c [2];
   logic [15:0] env_period [2];
   logic [3:0]  env_shape [2];
   logic        env_shape_tick [2];
   logic [7:0]  io_a_out [2];
   logic [7:0]  io_b_out [2];

   int n_vec = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   ay_regs #(.ADDR_HI(4'h0), .ATOMIC_PERIOD(1'b0)) u_dut0 (
      .clk(clk), .reset(reset), .wr(wr[0]), .rd(rd[0]), .a0(a0[0]), .din(din[0]),
      .dout(dout[0]), .rd_valid(rd_valid[0]), .tone_a(tone_a[0]), .tone_b(tone_b[0]),
      .tone_c(tone_c[0]), .noise_period(noise_period[0]), .mixer(mixer[0]),
      .amp_a(amp_a[0]), .amp_b(amp_b[0]), .amp_c(amp_c[0]), .env_period(env_period[0]),
      .env_shape(env_shape[0]), .env_shape_tick(env_shape_tick[0]),
      .io_a_out(io_a_out[0]), .io_b_out(io_b_out[0]), .io_a_in(io_a_in[0]), .io_b_in(io_b_in[0])
   );

   ay_regs #(.ADDR_HI(4'h1), .ATOMIC_PERIOD(1'b1)) u_dut1 (
      .clk(clk), .reset(reset), .wr(wr[1]), .rd(rd[1]), .a0(a0[1]), .din(din[1]),
      .dout(dout[1]), .rd_valid(rd_valid[1]), .tone_a(tone_a[1]), .tone_b(tone_b[1]),
      .tone_c(tone_c[1]), .noise_period(noise_period[1]), .mixer(mixer[1]),
      .amp_a(amp_a[1]), .amp_b(amp_b[1]), .amp_c(amp_c[1]), .env_period(env_period[1]),
      .env_shape(env_shape[1]), .env_shape_tick(env_shape_tick[1]),
      .io_a_out(io_a_out[1]), .io_b_out(io_b_out[1]), .io_a_in(io_a_in[1]), .io_b_in(io_b_in[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One bus cycle; returns 1 time unit after the edge that consumed it.
   task automatic bus_op(input int d, input logic w, input logic r, input logic a, input logic [7:0] data);
      wr[d] = w; rd[d] = r; a0[d] = a; din[d] = data;
      @(posedge clk); #1;
      wr[d] = 1'b0; rd[d] = 1'b0;
   endtask

   task automatic set_addr(input int d, input logic [7:0] b); bus_op(d, 1'b1, 1'b0, 1'b0, b); endtask
   task automatic wr_data(input int d, input logic [7:0] b);  bus_op(d, 1'b1, 1'b0, 1'b1, b); endtask
   task automatic rd_data(input int d);                       bus_op(d, 1'b0, 1'b1, 1'b1, 8'h00); endtask

   function automatic logic [31:0] all_out_or(input int d);
      all_out_or = {20'h0, tone_a[d]} | {20'h0, tone_b[d]} | {20'h0, tone_c[d]} |
                   {27'h0, noise_period[d]} | {24'h0, mixer[d]} | {27'h0, amp_a[d]} |
                   {27'h0, amp_b[d]} | {27'h0, amp_c[d]} | {16'h0, env_period[d]} |
                   {28'h0, env_shape[d]} | {24'h0, io_a_out[d]} | {24'h0, io_b_out[d]} |
                   {24'h0, dout[d]} | {31'h0, rd_valid[d]} | {31'h0, env_shape_tick[d]};
   endfunction

   initial begin
      for (int d = 0; d < 2; d++) begin
         wr[d] = 1'b0; rd[d] = 1'b0; a0[d] = 1'b0; din[d] = 8'h00;
         io_a_in[d] = 8'h00; io_b_in[d] = 8'h00;
      end
      reset = 1'b0;
      #3;
      check("reset_outs_dut0", all_out_or(0), 32'h0);
      check("reset_outs_dut1", all_out_or(1), 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // Data write with no address latched is ignored; read then floats.
      wr_data(0, 8'h55);
      check("no_addr_write", all_out_or(0), 32'h0);
      rd_data(0);
      check("no_addr_rd_valid", {31'h0, rd_valid[0]}, 32'h1);
      check("no_addr_rd_dout", {24'h0, dout[0]}, 32'hFF);

      // Tone period assembly and masked readback.
      set_addr(0, 8'h00); wr_data(0, 8'hAB);
      set_addr(0, 8'h01); wr_data(0, 8'hFC);
      check("tone_a", {20'h0, tone_a[0]}, 32'hCAB);
      rd_data(0);
      check("rd_r1_valid", {31'h0, rd_valid[0]}, 32'h1);
      check("rd_r1_dout", {24'h0, dout[0]}, 32'h0C);
      @(posedge clk); #1;
      check("rd_valid_pulse", {31'h0, rd_valid[0]}, 32'h0);
      check("dout_hold", {24'h0, dout[0]}, 32'h0C);

      // 5-bit masking on noise and amplitude.
      set_addr(0, 8'h06); wr_data(0, 8'hFF);
      check("noise_mask", {27'h0, noise_period[0]}, 32'h1F);
      rd_data(0);
      check("rd_r6", {24'h0, dout[0]}, 32'h1F);
      set_addr(0, 8'h08); wr_data(0, 8'hE7);
      check("amp_a_mask", {27'h0, amp_a[0]}, 32'h07);

      // Non-atomic R11 write shows immediately.
      set_addr(0, 8'h0B); wr_data(0, 8'h77);
      check("env_period_direct", {16'h0, env_period[0]}, 32'h0077);

      // Back-to-back R13 writes give back-to-back ticks.
      set_addr(0, 8'h0D);
      check("tick_idle", {31'h0, env_shape_tick[0]}, 32'h0);
      wr[0] = 1'b1; a0[0] = 1'b1; din[0] = 8'hFA;
      @(posedge clk); #1;
      check("tick_1", {31'h0, env_shape_tick[0]}, 32'h1);
      check("env_shape", {28'h0, env_shape[0]}, 32'hA);
      @(posedge clk); #1;
      wr[0] = 1'b0;
      check("tick_2", {31'h0, env_shape_tick[0]}, 32'h1);
      @(posedge clk); #1;
      check("tick_off", {31'h0, env_shape_tick[0]}, 32'h0);

      // R14 readback follows the mixer direction bit.
      io_a_in[0] = 8'h5A;
      set_addr(0, 8'h0E); wr_data(0, 8'hC3);
      check("io_a_out", {24'h0, io_a_out[0]}, 32'hC3);
      set_addr(0, 8'h07); wr_data(0, 8'h00);
      set_addr(0, 8'h0E); rd_data(0);
      check("rd_r14_input", {24'h0, dout[0]}, 32'h5A);
      set_addr(0, 8'h07); wr_data(0, 8'h40);
      set_addr(0, 8'h0E); rd_data(0);
      check("rd_r14_output", {24'h0, dout[0]}, 32'hC3);

      // Read from the address port floats.
      bus_op(0, 1'b0, 1'b1, 1'b0, 8'h00);
      check("rd_a0_0_valid", {31'h0, rd_valid[0]}, 32'h1);
      check("rd_a0_0_dout", {24'h0, dout[0]}, 32'hFF);

      // Atomic envelope period with ADDR_HI = 1.
      set_addr(1, 8'h1B); wr_data(1, 8'h34);
      check("atomic_hold", {16'h0, env_period[1]}, 32'h0000);
      rd_data(1);
      check("rd_shadow", {24'h0, dout[1]}, 32'h34);
      set_addr(1, 8'h1C); wr_data(1, 8'h12);
      check("atomic_commit", {16'h0, env_period[1]}, 32'h1234);

      // Chip-select mismatch drops the address.
      set_addr(1, 8'h07); wr_data(1, 8'h55);
      check("cs_miss_write", {24'h0, mixer[1]}, 32'h00);
      rd_data(1);
      check("cs_miss_rd", {24'h0, dout[1]}, 32'hFF);
      set_addr(1, 8'h17); wr_data(1, 8'h38);
      check("cs_hit_mixer", {24'h0, mixer[1]}, 32'h38);
      wr_data(1, 8'h39);
      check("addr_persist", {24'h0, mixer[1]}, 32'h39);
      bus_op(1, 1'b1, 1'b1, 1'b1, 8'h3A);
      check("wr_rd_write", {24'h0, mixer[1]}, 32'h3A);
      check("wr_rd_no_valid", {31'h0, rd_valid[1]}, 32'h0);

      // Reset mid-access cancels the pending pulse at once.
      set_addr(0, 8'h00); rd_data(0);
      check("pre_reset_valid", {31'h0, rd_valid[0]}, 32'h1);
      reset = 1'b0; #1;
      check("reset_cancel", {31'h0, rd_valid[0]}, 32'h0);
      check("reset_clear", all_out_or(0), 32'h0);
      reset = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/ay_regs.md
Name: ay_regs

Overview:
- CPU-facing register file and sequencer for the AY-3-891x core.
- Decodes Z8S180 I/O writes and reads into the 16 AY registers (R0–R15) using an address-latch/data-port pair.
- Drives static configuration to the tone, noise, mixer and amplitude datapaths, and `env_period`/`env_shape` to `ay_env`.
- Generates the one-cycle `env_shape_tick` that restarts the envelope. Sits between the bus decode logic and the `ay_*` generator blocks.

Parameters:
- ADDR_HI, 4'h0, upper-nibble chip-select value; a latched address is valid only when `din[7:4]` == ADDR_HI.
- ATOMIC_PERIOD, 0, 1 = an R11 write is held in a shadow register and `env_period` updates only on an R12 write; 0 = each byte updates immediately.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- wr  in  1  one-clk write strobe, already synchronized to clk
- rd  in  1  one-clk read strobe, already synchronized to clk
- a0  in  1  0 = address-latch port, 1 = data port
- din  in  8  write data
- dout  out  8  read data, valid when rd_valid
- rd_valid  out  1  one-clk pulse, 1 cycle after an accepted rd
- tone_a, tone_b, tone_c  out  12 each  tone periods {R1[3:0],R0}, {R3[3:0],R2}, {R5[3:0],R4}
- noise_period  out  5  R6[4:0]
- mixer  out  8  R7
- amp_a, amp_b, amp_c  out  5 each  R8[4:0], R9[4:0], R10[4:0]
- env_period  out  16  {R12,R11}
- env_shape  out  4  R13[3:0]
- env_shape_tick  out  1  one-clk pulse per R13 write
- io_a_out, io_b_out  out  8 each  R14, R15
- io_a_in, io_b_in  in  8 each  external port pins

Behaviour:
- Reset (reset = 0, async):
  - All registers, the shadow register and the address latch clear to 0. The address-valid flag clears to 0.
  - All outputs go to 0, including dout, rd_valid and env_shape_tick.
  - Reset release is synchronous to clk.
- Address write (wr & !a0):
  - If din[7:4] == ADDR_HI: latch din[3:0] and set addr_valid = 1.
  - Else: clear addr_valid to 0.
- Data write (wr & a0 & addr_valid): store din into the latched register, masked to implemented width.
  - R1, R3, R5, R13 keep 4 bits; R6, R8, R9, R10 keep 5 bits; all others keep 8.
  - A data write with addr_valid = 0 is ignored.
- Output timing: outputs reflect the stored value on the clk edge after the write edge, i.e. visible 1 cycle after wr.
- env_shape_tick:
  - Asserted for exactly 1 clk, in the same cycle env_shape first shows the new value.
  - Fires on every R13 write, including same-value rewrites.
  - Back-to-back R13 writes produce back-to-back ticks.
- ATOMIC_PERIOD = 1:
  - An R11 write goes to the shadow only; env_period is unchanged.
  - An R12 write loads {din, shadow} into env_period in one edge.
  - Readback of R11 returns the shadow.
- ATOMIC_PERIOD = 0: an R11 write updates env_period[7:0] immediately.
- Read (rd & a0 & addr_valid & !wr):
  - Next cycle: rd_valid = 1; dout = masked register value, upper unimplemented bits read 0.
  - R14 returns io_a_in when mixer[6] = 0 (input), else R14.
  - R15 returns io_b_in when mixer[7] = 0, else R15.
  - io_*_in is sampled in the rd cycle.
- Invalid reads:
  - rd with a0 = 0, or with addr_valid = 0: rd_valid = 1, dout = 8'hFF (bus float).
  - dout holds its value when rd_valid = 0.
- wr and rd in the same cycle: the write is performed; the rd is dropped (no rd_valid).
- The address latch persists across data accesses, so repeated data writes hit the same register.
- Reset asserted mid-access: any pending rd_valid or env_shape_tick is cancelled immediately.

Test Plan:
1. Reset → all outputs 0; release reset, a0 = 1 write of 8'h55 with no prior address → no register changes.
2. Write addr 8'h00, data 8'hAB; addr 8'h01, data 8'hFC → tone_a = 12'hCAB. Read R1 → rd_valid one cycle later, dout = 8'h0C.
3. Write R13 = 4'b1010 twice in consecutive data cycles → env_shape = 4'hA, env_shape_tick high for exactly 2 consecutive cycles.
4. ATOMIC_PERIOD = 1: write R11 = 8'h34 → env_period stays 16'h0000; write R12 = 8'h12 → env_period = 16'h1234 in a single edge, with no intermediate 16'h0034.
5. Set io_a_in = 8'h5A, R14 = 8'hC3. Mixer = 8'h00 → read R14 returns 8'h5A. Mixer = 8'h40 → read R14 returns 8'hC3.
6. ADDR_HI = 4'h1:
   - Address write 8'h07 → next data write ignored, read returns 8'hFF.
   - Address write 8'h17 → write 8'h38 sets mixer = 8'h38.
   - Assert wr and rd together → write occurs, no rd_valid.
